vga_avn_sram: RTL and testbench
===============================

// Module: vga_avn_sram
// PURPOSE
//  Avalon-MM pipelined slave to asynchronous 16-bit SRAM controller (IS61LV25616 class).
//  Sits directly downstream of the framebuffer Avalon mux and consumes its out_avn_* bus.
//  Converts each accepted read/write into a timed SRAM access with registered, glitch-free controls.
//  Returns read data on avn_readdatavalid; one access in flight at a time.
// PARAMETERS
//  AVN_AW      18  Avalon word address width; equals SRAM address width.
//  AVN_DW      16  Avalon/SRAM data width; byte lanes = AVN_DW/8 (2).
//  READ_WAIT   1   extra cycles OE_n held low beyond 1 (access time margin), 0..15.
//  WRITE_WAIT  1   extra cycles WE_n held low beyond 1, 0..15.
// PORTS
//  clk                 in   1         system clock
//  rst                 in   1         asynchronous reset, active-high
//  avn_read            in   1         read request
//  avn_write           in   1         write request
//  avn_address         in   AVN_AW    word address
//  avn_writedata       in   AVN_DW    write data
//  avn_byteenable      in   AVN_DW/8  byte enables, bit0 = [7:0]
//  avn_readdata        out  AVN_DW    read data, valid with avn_readdatavalid
//  avn_readdatavalid   out  1         one-cycle read-return pulse
//  avn_waitrequest     out  1         request not accepted this cycle
//  sram_addr           out  AVN_AW    SRAM address
//  sram_dq_i           in   AVN_DW    SRAM data in (from top-level tristate)
//  sram_dq_o           out  AVN_DW    SRAM data out
//  sram_dq_oe          out  1         1 = drive sram_dq_o onto the pad
//  sram_ce_n/oe_n/we_n out  1 each    SRAM chip, output and write enables, active-low
//  sram_ub_n/lb_n      out  1 each    upper/lower byte enables, active-low
// BEHAVIOUR
//  - Reset (async): state IDLE; ce_n/oe_n/we_n/ub_n/lb_n=1; sram_addr/dq_o/avn_readdata=0;
//    dq_oe=0; readdatavalid=0. avn_waitrequest = rst | (state!=IDLE).
//  - Mid-access reset aborts immediately: no readdatavalid, no partial-cycle resumption.
//  - FSM IDLE, READ, WRITE, WHOLD; 4-bit down-counter cnt.
//  - IDLE: waitrequest=0. avn_write -> latch addr/data/~byteenable into sram_*, cnt<=WRITE_WAIT, WRITE.
//    avn_read (no write) -> latch addr/~byteenable, cnt<=READ_WAIT, READ. Both set: write wins,
//    read ignored. Neither: SRAM controls stay deasserted.
//  - READ: ce_n=0, oe_n=0, dq_oe=0. cnt!=0: cnt--. cnt==0: avn_readdata<=sram_dq_i,
//    readdatavalid<=1 next cycle, -> IDLE with ce_n/oe_n=1.
//    Latency: accept edge E -> readdatavalid high in cycle E+READ_WAIT+2, exactly one cycle.
//  - WRITE: ce_n=0, we_n=0, dq_oe=1 for WRITE_WAIT+1 cycles, then -> WHOLD.
//  - WHOLD: one cycle, we_n=1, ce_n=0, dq_oe=1, addr/data held (hold time + bus turnaround), -> IDLE.
//    Write occupancy: WRITE_WAIT+2 cycles after acceptance.
//  - byteenable=0 write still runs full cycle, with ub_n=lb_n=1 (no bytes written).
//  - oe_n=0 and dq_oe=1 never coincide. All sram_* outputs are flop outputs.
//  - At most one outstanding read; next request accepted in the cycle state returns to IDLE
//    (the same cycle a read's readdatavalid is high).
// TESTING
//  1 Reset: rst pulse mid-sim -> all *_n=1, dq_oe=0, readdatavalid=0, waitrequest=1 while rst high.
//  2 Write 0x00123 <= 0xBEEF, be=2'b11, WRITE_WAIT=1 -> we_n low 2 cycles, WHOLD 1 cycle,
//    dq_o=0xBEEF, waitrequest high 3 cycles.
//  3 Read 0x00123 (SRAM model holds 0xBEEF, READ_WAIT=1) -> readdatavalid single pulse at E+3,
//    readdata=0xBEEF, oe_n low 2 cycles.
//  4 Write 0x00123 <= 0x12AB, be=2'b01 -> lb_n=0, ub_n=1; readback = 0xBEAB.
//  5 Write 0x00010 then read 0x00010 held continuously -> read accepted first IDLE cycle;
//    oe_n=0 never overlaps dq_oe=1; read data matches.
//  6 rst asserted during READ cycle 1 -> no readdatavalid; after release, read 0x00123 returns 0xBEAB.

Source files
------------

// File: rtl/vga_avn_sram.sv
// ---------------------------------------------------------------------------
// vga_avn_sram
//
// Avalon-MM pipelined slave that turns each accepted read or write into one
// timed access on an asynchronous 16-bit SRAM (IS61LV25616 class). Only one
// access is in flight at a time. Every SRAM-side output comes straight from a
// flop, so the chip sees glitch-free controls.
//
// Access timing (E = clock edge that accepts the request):
//   read : CE_n/OE_n low for READ_WAIT+1 cycles, data captured on the last
//          edge, readdatavalid high for one cycle starting at E+READ_WAIT+2.
//   write: CE_n/WE_n low with the data bus driven for WRITE_WAIT+1 cycles,
//          then one WHOLD cycle (WE_n high, CE_n low, bus still driven) for
//          address/data hold time and bus turnaround.
//
// Ports
//   i_clk                  system clock
//   i_rst                  asynchronous reset, active-high
//   i_avn_read/write       Avalon read / write request (write wins if both)
//   i_avn_address          word address
//   i_avn_writedata        write data
//   i_avn_byteenable       byte enables, bit0 = [7:0]
//   o_avn_readdata         read data, valid with o_avn_readdatavalid
//   o_avn_readdatavalid    one-cycle read-return pulse
//   o_avn_waitrequest      request not accepted this cycle
//   o_sram_addr            SRAM address
//   i_sram_dq              SRAM data from the top-level tristate
//   o_sram_dq              SRAM data towards the pad
//   o_sram_dq_oe           1 = drive o_sram_dq onto the pad
//   o_sram_ce_n/oe_n/we_n  chip, output and write enables, active-low
//   o_sram_ub_n/lb_n       upper / lower byte enables, active-low
// ---------------------------------------------------------------------------
module vga_avn_sram #(
    parameter int unsigned AVN_AW     = 18,
    parameter int unsigned AVN_DW     = 16,  // two byte lanes: ub/lb map to be[1]/be[0]
    parameter int unsigned READ_WAIT  = 1,   // 0..15
    parameter int unsigned WRITE_WAIT = 1    // 0..15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_avn_read,
    input  logic                  i_avn_write,
    input  logic [AVN_AW-1:0]     i_avn_address,
    input  logic [AVN_DW-1:0]     i_avn_writedata,
    input  logic [AVN_DW/8-1:0]   i_avn_byteenable,
    output logic [AVN_DW-1:0]     o_avn_readdata,
    output logic                  o_avn_readdatavalid,
    output logic                  o_avn_waitrequest,
    output logic [AVN_AW-1:0]     o_sram_addr,
    input  logic [AVN_DW-1:0]     i_sram_dq,
    output logic [AVN_DW-1:0]     o_sram_dq,
    output logic                  o_sram_dq_oe,
    output logic                  o_sram_ce_n,
    output logic                  o_sram_oe_n,
    output logic                  o_sram_we_n,
    output logic                  o_sram_ub_n,
    output logic                  o_sram_lb_n
);

    localparam logic [3:0] READ_WAIT_C  = 4'(READ_WAIT);
    localparam logic [3:0] WRITE_WAIT_C = 4'(WRITE_WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_WHOLD
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [AVN_AW-1:0]   r_addr;
    logic [AVN_DW-1:0]   r_dq;
    logic                r_dq_oe;
    logic                r_ce_n;
    logic                r_oe_n;
    logic                r_we_n;
    logic                r_ub_n;
    logic                r_lb_n;
    logic [AVN_DW-1:0]   r_readdata;
    logic                r_readdatavalid;

    // Requests are only taken in IDLE; reset also holds the master off.
    // NOTE: plain continuous assigns cover every case, so no latch can be
    // inferred here; anything written in always_comb would need a default.
    assign o_avn_waitrequest = i_rst | (r_state != S_IDLE);

    // Single FSM with registered outputs. The SRAM controls are set on the
    // edge that enters a state, so each is a clean flop output.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: every register here is reset explicitly; there is no
            // storage array in this block, so nothing is left unreset.
            r_state         <= S_IDLE;
            r_cnt           <= 4'd0;
            r_addr          <= '0;
            r_dq            <= '0;
            r_dq_oe         <= 1'b0;
            r_ce_n          <= 1'b1;
            r_oe_n          <= 1'b1;
            r_we_n          <= 1'b1;
            r_ub_n          <= 1'b1;
            r_lb_n          <= 1'b1;
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            // Read-return is a single-cycle pulse unless raised below.
            r_readdatavalid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_avn_write) begin
                        // Write takes priority over a simultaneous read.
                        r_addr  <= i_avn_address;
                        r_dq    <= i_avn_writedata;
                        r_ub_n  <= ~i_avn_byteenable[1];
                        r_lb_n  <= ~i_avn_byteenable[0];
                        r_ce_n  <= 1'b0;
                        r_we_n  <= 1'b0;
                        r_dq_oe <= 1'b1;
                        r_cnt   <= WRITE_WAIT_C;
                        r_state <= S_WRITE;
                    end else if (i_avn_read) begin
                        r_addr  <= i_avn_address;
                        r_ub_n  <= ~i_avn_byteenable[1];
                        r_lb_n  <= ~i_avn_byteenable[0];
                        r_ce_n  <= 1'b0;
                        r_oe_n  <= 1'b0;
                        r_cnt   <= READ_WAIT_C;
                        r_state <= S_READ;
                    end
                end

                S_READ: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // Data has been stable for the full OE_n window;
                        // capture it on the same edge that releases the chip.
                        r_readdata      <= i_sram_dq;
                        r_readdatavalid <= 1'b1;
                        r_ce_n          <= 1'b1;
                        r_oe_n          <= 1'b1;
                        r_ub_n          <= 1'b1;
                        r_lb_n          <= 1'b1;
                        r_state         <= S_IDLE;
                    end
                end

                S_WRITE: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // WE_n rises first while CE_n, address and data stay
                        // put, giving the SRAM its data-hold window.
                        r_we_n  <= 1'b1;
                        r_state <= S_WHOLD;
                    end
                end

                S_WHOLD: begin
                    // Bus released only now, one cycle after WE_n, so a
                    // following read cannot turn OE_n on while we drive.
                    r_ce_n  <= 1'b1;
                    r_dq_oe <= 1'b0;
                    r_ub_n  <= 1'b1;
                    r_lb_n  <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_sram_addr         = r_addr;
    assign o_sram_dq           = r_dq;
    assign o_sram_dq_oe        = r_dq_oe;
    assign o_sram_ce_n         = r_ce_n;
    assign o_sram_oe_n         = r_oe_n;
    assign o_sram_we_n         = r_we_n;
    assign o_sram_ub_n         = r_ub_n;
    assign o_sram_lb_n         = r_lb_n;
    assign o_avn_readdata      = r_readdata;
    assign o_avn_readdatavalid = r_readdatavalid;

    // The SRAM must never drive the bus while we do.
    a_no_bus_contention: assert property (@(posedge i_clk) disable iff (i_rst)
        !(!r_oe_n && r_dq_oe));

endmodule

// File: tb/tb_vga_avn_sram.sv
// ---------------------------------------------------------------------------
// tb_vga_avn_sram
//
// Self-checking bench for vga_avn_sram. A behavioural SRAM model answers the
// controller; expected read data is queued when a read is issued and popped
// when readdatavalid is seen. Multi-cycle waveforms are compared against
// per-cycle expectation tables.
// ---------------------------------------------------------------------------
module tb_vga_avn_sram;

    localparam int AW = 18;
    localparam int DW = 16;

    logic            clk;
    logic            rst;
    logic            avn_read;
    logic            avn_write;
    logic [AW-1:0]   avn_address;
    logic [DW-1:0]   avn_writedata;
    logic [1:0]      avn_byteenable;
    logic [DW-1:0]   avn_readdata;
    logic            avn_readdatavalid;
    logic            avn_waitrequest;
    logic [AW-1:0]   sram_addr;
    logic [DW-1:0]   sram_dq_i;
    logic [DW-1:0]   sram_dq_o;
    logic            sram_dq_oe;
    logic            sram_ce_n;
    logic            sram_oe_n;
    logic            sram_we_n;
    logic            sram_ub_n;
    logic            sram_lb_n;

    vga_avn_sram #(
        .AVN_AW     (AW),
        .AVN_DW     (DW),
        .READ_WAIT  (1),
        .WRITE_WAIT (1)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_avn_read          (avn_read),
        .i_avn_write         (avn_write),
        .i_avn_address       (avn_address),
        .i_avn_writedata     (avn_writedata),
        .i_avn_byteenable    (avn_byteenable),
        .o_avn_readdata      (avn_readdata),
        .o_avn_readdatavalid (avn_readdatavalid),
        .o_avn_waitrequest   (avn_waitrequest),
        .o_sram_addr         (sram_addr),
        .i_sram_dq           (sram_dq_i),
        .o_sram_dq           (sram_dq_o),
        .o_sram_dq_oe        (sram_dq_oe),
        .o_sram_ce_n         (sram_ce_n),
        .o_sram_oe_n         (sram_oe_n),
        .o_sram_we_n         (sram_we_n),
        .o_sram_ub_n         (sram_ub_n),
        .o_sram_lb_n         (sram_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM model ----------------
    logic [DW-1:0] mem [0:262143];

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = '0;
    end

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_dq_o[7:0];
            if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dq_o[15:8];
        end
    end

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;

    // ---------------- bookkeeping ----------------
    int n_checks  = 0;
    int n_fail    = 0;
    int rdv_count = 0;
    int n_pushed  = 0;
    int overlap_cnt = 0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard / monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (!sram_oe_n && sram_dq_oe) overlap_cnt++;
        if (avn_readdatavalid) begin
            rdv_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rdv: got readdata 0x%0h with nothing outstanding (t=%0t)",
                         avn_readdata, $time);
            end else begin
                check("read_data", {16'h0, avn_readdata}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    // Drive one request starting at a negedge; returns 1 ns after the
    // accepting edge. waited = number of cycles waitrequest held it off.
    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [1:0] be, input logic [DW-1:0] exp,
                         input bit expect_rd, output int waited);
        waited = 0;
        @(negedge clk);
        avn_write      = wr;
        avn_read       = ~wr;
        avn_address    = a;
        avn_writedata  = d;
        avn_byteenable = be;
        while (avn_waitrequest && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 40) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: waitrequest still high after %0d cycles", waited);
        end else begin
            if (!wr && expect_rd) begin
                exp_q.push_back(exp);
                n_pushed++;
            end
            @(posedge clk);
            #1;
        end
        avn_write = 1'b0;
        avn_read  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("drain_outstanding", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl_n"}, {27'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        check({tag, "_dq_oe"}, {31'h0, sram_dq_oe}, 32'h0);
        check({tag, "_rdv"},   {31'h0, avn_readdatavalid}, 32'h0);
        check({tag, "_wait"},  {31'h0, avn_waitrequest}, 32'h1);
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    be;
        logic [DW-1:0] exp_rd;   // expected read data (reads only)
        logic [1:0]    exp_bl;   // expected {ub_n, lb_n} during the access
    } vec_t;

    vec_t vecs [10];

    // Per-cycle expectations: {we_n, ce_n, oe_n, dq_oe, waitrequest, readdatavalid}
    logic [5:0] wr_cyc [4];
    logic [5:0] rd_cyc [4];

    initial begin
        int w;
        int rc;

        vecs[0] = '{wr:1'b1, addr:18'h00123, data:16'h12AB, be:2'b01, exp_rd:16'h0000, exp_bl:2'b10};
        vecs[1] = '{wr:1'b0, addr:18'h00123, data:16'h0000, be:2'b11, exp_rd:16'hBEAB, exp_bl:2'b00};
        vecs[2] = '{wr:1'b1, addr:18'h3FFFF, data:16'hA5A5, be:2'b11, exp_rd:16'h0000, exp_bl:2'b00};
        vecs[3] = '{wr:1'b1, addr:18'h00000, data:16'h1234, be:2'b11, exp_rd:16'h0000, exp_bl:2'b00};
        vecs[4] = '{wr:1'b0, addr:18'h3FFFF, data:16'h0000, be:2'b11, exp_rd:16'hA5A5, exp_bl:2'b00};
        vecs[5] = '{wr:1'b0, addr:18'h00000, data:16'h0000, be:2'b11, exp_rd:16'h1234, exp_bl:2'b00};
        vecs[6] = '{wr:1'b1, addr:18'h3FFFF, data:16'hFFFF, be:2'b00, exp_rd:16'h0000, exp_bl:2'b11};
        vecs[7] = '{wr:1'b0, addr:18'h3FFFF, data:16'h0000, be:2'b11, exp_rd:16'hA5A5, exp_bl:2'b00};
        vecs[8] = '{wr:1'b1, addr:18'h00000, data:16'hCD99, be:2'b10, exp_rd:16'h0000, exp_bl:2'b01};
        vecs[9] = '{wr:1'b0, addr:18'h00000, data:16'h0000, be:2'b11, exp_rd:16'hCD34, exp_bl:2'b00};

        wr_cyc[0] = 6'b001110;
        wr_cyc[1] = 6'b001110;
        wr_cyc[2] = 6'b101110;
        wr_cyc[3] = 6'b111000;
        rd_cyc[0] = 6'b100010;
        rd_cyc[1] = 6'b100010;
        rd_cyc[2] = 6'b111001;
        rd_cyc[3] = 6'b111000;

        rst            = 1'b0;
        avn_read       = 1'b0;
        avn_write      = 1'b0;
        avn_address    = '0;
        avn_writedata  = '0;
        avn_byteenable = '0;

        // ---- power-on reset ----
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("por");
        check("por_addr", {14'h0, sram_addr}, 32'h0);
        check("por_dq_o", {16'h0, sram_dq_o}, 32'h0);
        check("por_readdata", {16'h0, avn_readdata}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("por_release_wait", {31'h0, avn_waitrequest}, 32'h0);

        // ---- write 0x00123 <= 0xBEEF, cycle-accurate waveform ----
        issue(1'b1, 18'h00123, 16'hBEEF, 2'b11, 16'h0, 1'b0, w);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("wr_wave_c%0d", c),
                  {26'h0, sram_we_n, sram_ce_n, sram_oe_n, sram_dq_oe, avn_waitrequest, avn_readdatavalid},
                  {26'h0, wr_cyc[c]});
            if (c == 2) begin
                check("whold_dq_o", {16'h0, sram_dq_o}, 32'h0000BEEF);
                check("whold_addr", {14'h0, sram_addr}, 32'h00123);
                check("whold_bl", {30'h0, sram_ub_n, sram_lb_n}, 32'h0);
            end
        end

        // ---- read back 0x00123, cycle-accurate waveform ----
        issue(1'b0, 18'h00123, 16'h0, 2'b11, 16'hBEEF, 1'b1, w);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rd_wave_c%0d", c),
                  {26'h0, sram_we_n, sram_ce_n, sram_oe_n, sram_dq_oe, avn_waitrequest, avn_readdatavalid},
                  {26'h0, rd_cyc[c]});
            if (c == 2) check("rd_readdata", {16'h0, avn_readdata}, 32'h0000BEEF);
        end

        // ---- table-driven traffic (partial bytes, limits, be=0) ----
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].exp_rd, 1'b1, w);
            check($sformatf("vec%0d_addr", i), {14'h0, sram_addr}, {14'h0, vecs[i].addr});
            check($sformatf("vec%0d_bl", i), {30'h0, sram_ub_n, sram_lb_n}, {30'h0, vecs[i].exp_bl});
            if (vecs[i].wr) check($sformatf("vec%0d_dq_o", i), {16'h0, sram_dq_o}, {16'h0, vecs[i].data});
        end
        wait_drain();

        // ---- write then read held continuously: read taken at first IDLE ----
        issue(1'b1, 18'h00010, 16'hC3A5, 2'b11, 16'h0, 1'b0, w);
        avn_read    = 1'b1;
        avn_address = 18'h00010;
        avn_byteenable = 2'b11;
        w = 0;
        @(negedge clk);
        while (avn_waitrequest && w < 40) begin
            w++;
            @(negedge clk);
        end
        check("held_read_wait_cycles", w, 3);
        exp_q.push_back(16'hC3A5);
        n_pushed++;
        @(posedge clk);
        #1;
        avn_read = 1'b0;
        wait_drain();

        // ---- reset pulse in the middle of a write ----
        issue(1'b1, 18'h00200, 16'h7777, 2'b11, 16'h0, 1'b0, w);
        rst = 1'b1;
        #1;
        check_reset_outputs("midwr");
        @(negedge clk);
        check_reset_outputs("midwr_held");
        rst = 1'b0;
        #1;
        check("midwr_release_wait", {31'h0, avn_waitrequest}, 32'h0);

        // ---- reset during the first READ cycle: no data returned ----
        issue(1'b0, 18'h00123, 16'h0, 2'b11, 16'h0, 1'b0, w);
        rc = rdv_count;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrd");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrd_no_rdv", rdv_count, rc);
        issue(1'b0, 18'h00123, 16'h0, 2'b11, 16'hBEAB, 1'b1, w);
        wait_drain();

        repeat (3) @(negedge clk);
        check("rdv_pulse_total", rdv_count, n_pushed);
        check("bus_overlap_cycles", overlap_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
